// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: round-robin arbitration, operand latch,
// result capture and committed-flag register, with one op in flight at a time.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_val1,
  input  logic [31:0] req0_val2,
  input  logic [3:0]  req0_cmd,
  input  logic        req0_s,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_val1,
  input  logic [31:0] req1_val2,
  input  logic [3:0]  req1_cmd,
  input  logic        req1_s,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic [3:0]  alu_cmd,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_sr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_sr,
  output logic [3:0]  status_reg
);

  localparam logic [3:0] CMP_EXE = 4'b1010;
  localparam logic [3:0] TST_EXE = 4'b1011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant_any, grant_id;
  logic        ready0_int, ready1_int;
  logic        hs;
  logic [31:0] op_val1, op_val2;
  logic [3:0]  op_cmd;
  logic        op_s, op_id;
  logic        flag_commit;

  // Tie goes to whoever did not win last time; a lone requester always wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  always_comb begin
    state_nxt  = state;
    ready0_int = 1'b0;
    ready1_int = 1'b0;
    hs         = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          ready0_int = ~grant_id;
          ready1_int = grant_id;
          hs         = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Readies are gated by rst_n so they drop the instant reset asserts.
  assign req0_ready = rst_n & ready0_int;
  assign req1_ready = rst_n & ready1_int;

  assign flag_commit = op_s | (op_cmd == CMP_EXE) | (op_cmd == TST_EXE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_val1    <= '0;
      op_val2    <= '0;
      op_cmd     <= '0;
      op_s       <= 1'b0;
      op_id      <= 1'b0;
      rsp_result <= '0;
      rsp_sr     <= '0;
      status_reg <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        last_grant <= grant_id;
        op_id      <= grant_id;
        op_val1    <= grant_id ? req1_val1 : req0_val1;
        op_val2    <= grant_id ? req1_val2 : req0_val2;
        op_cmd     <= grant_id ? req1_cmd  : req0_cmd;
        op_s       <= grant_id ? req1_s    : req0_s;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_sr     <= alu_sr;
        if (flag_commit) status_reg <= alu_sr;
      end
    end
  end

  assign alu_val1 = op_val1;
  assign alu_val2 = op_val2;
  assign alu_cmd  = op_cmd;
  assign alu_cin  = status_reg[2];
  assign rsp_id   = op_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: an ALU stub, a transaction-level model checked every
// cycle, and literal expectations for the named scenarios.
module tb_alu_arbiter;

  localparam logic [3:0] MOV = 4'b0001, ADD = 4'b0010, ADC = 4'b0011, SUB = 4'b0100;
  localparam logic [3:0] SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111, EOR = 4'b1000;
  localparam logic [3:0] MVN = 4'b1001, CMP = 4'b1010, TST = 4'b1011, UND = 4'b1111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_val1 = 0, req0_val2 = 0, req1_val1 = 0, req1_val2 = 0;
  logic [3:0]  req0_cmd = 0, req1_cmd = 0;
  logic        req0_s = 0, req1_s = 0;
  logic [31:0] alu_val1, alu_val2, alu_result, rsp_result;
  logic [3:0]  alu_cmd, alu_sr, rsp_sr, status_reg;
  logic        alu_cin, rsp_valid, rsp_id;
  logic        rsp_ready = 1;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_val1(req0_val1),
    .req0_val2(req0_val2), .req0_cmd(req0_cmd), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_val1(req1_val1),
    .req1_val2(req1_val2), .req1_cmd(req1_cmd), .req1_s(req1_s),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_sr(alu_sr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_sr(rsp_sr), .status_reg(status_reg)
  );

  // ALU behaviour; flags packed {Z,C,N,V} above the 32-bit result.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] cmd, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v, known;
    w = '0; r = '0; c = 1'b0; v = 1'b0; known = 1'b1;
    case (cmd)
      MOV: r = b;
      MVN: r = ~b;
      ADD, ADC: begin
        w = {1'b0, a} + {1'b0, b} + ((cmd == ADC) ? {32'b0, cin} : 33'd0);
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      SUB, CMP, SBC: begin
        w = {1'b0, a} + {1'b0, ~b} + ((cmd == SBC) ? {32'b0, cin} : 33'd1);
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      AND, TST: r = a & b;
      ORR: r = a | b;
      EOR: r = a ^ b;
      default: known = 1'b0;
    endcase
    if (known) alu_fn = {(r == 32'd0), c, r[31], v, r};
    else       alu_fn = {4'b0000, 32'h0BAD0BAD};
  endfunction

  always_comb {alu_sr, alu_result} = alu_fn(alu_val1, alu_val2, alu_cmd, alu_cin);

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    total++; bad++;
    $display("FAIL %s: timed out, expected event within bound", nm);
  endtask

  // Transaction model: at most one op held; it answers two cycles after acceptance.
  logic        m_busy = 0, m_stage = 0, m_last = 1, m_id = 0, m_s = 0;
  logic [31:0] m_v1 = 0, m_v2 = 0, m_res = 0;
  logic [3:0]  m_cmd = 0, m_sr = 0, m_status = 0;
  logic        log_id[$];
  logic [31:0] log_res[$];
  logic [3:0]  log_sr[$];

  always @(negedge clk) begin
    logic g, e_r0, e_r1, e_v;
    if (!rst_n) begin
      m_busy = 0; m_stage = 0; m_last = 1; m_id = 0; m_s = 0;
      m_v1 = 0; m_v2 = 0; m_cmd = 0; m_res = 0; m_sr = 0; m_status = 0;
      chk("rst req0_ready", 32'(req0_ready), 32'(0));
      chk("rst req1_ready", 32'(req1_ready), 32'(0));
      chk("rst rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst status_reg", 32'(status_reg), 32'(0));
      chk("rst alu_val1", alu_val1, 32'(0));
      chk("rst rsp_result", rsp_result, 32'(0));
      chk("rst rsp_sr", 32'(rsp_sr), 32'(0));
      chk("rst rsp_id", 32'(rsp_id), 32'(0));
    end else begin
      g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e_r0 = !m_busy && req0_valid && !g;
      e_r1 = !m_busy && req1_valid && g;
      e_v  = m_busy && m_stage;
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_v));
      chk("alu_val1", alu_val1, m_v1);
      chk("alu_val2", alu_val2, m_v2);
      chk("alu_cmd", 32'(alu_cmd), 32'(m_cmd));
      chk("alu_cin", 32'(alu_cin), 32'(m_status[2]));
      chk("status_reg", 32'(status_reg), 32'(m_status));
      if (e_v) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_sr", 32'(rsp_sr), 32'(m_sr));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
      end
      if (rsp_valid && rsp_ready) begin
        log_id.push_back(rsp_id); log_res.push_back(rsp_result); log_sr.push_back(rsp_sr);
      end
      if (!m_busy) begin
        if (req0_valid || req1_valid) begin
          m_id = g; m_last = g; m_busy = 1; m_stage = 0;
          m_v1 = g ? req1_val1 : req0_val1; m_v2 = g ? req1_val2 : req0_val2;
          m_cmd = g ? req1_cmd : req0_cmd; m_s = g ? req1_s : req0_s;
        end
      end else if (!m_stage) begin
        {m_sr, m_res} = alu_fn(m_v1, m_v2, m_cmd, m_status[2]);
        if (m_s || m_cmd == CMP || m_cmd == TST) m_status = m_sr;
        m_stage = 1;
      end else if (rsp_ready) begin
        m_busy = 0;
      end
    end
  end

  task automatic wait_ready(input logic k);
    int t = 0;
    forever begin
      @(negedge clk);
      if ((!k && req0_ready) || (k && req1_ready)) break;
      t++;
      if (t > 50) begin tmo("wait_ready"); break; end
    end
  endtask

  task automatic wait_rsp();
    int t = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      t++;
      if (t > 50) begin tmo("wait_rsp"); break; end
    end
  endtask

  task automatic wait_log(input int n);
    int t = 0;
    while (log_res.size() < n) begin
      @(posedge clk); #1;
      t++;
      if (t > 60) begin tmo("wait_log"); break; end
    end
  endtask

  task automatic do_op(input logic k, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] cmd, input logic s, output int lat, output logic cin);
    int hs;
    if (!k) begin req0_val1 = a; req0_val2 = b; req0_cmd = cmd; req0_s = s; req0_valid = 1; end
    else    begin req1_val1 = a; req1_val2 = b; req1_cmd = cmd; req1_s = s; req1_valid = 1; end
    wait_ready(k);
    hs = cyc;
    @(posedge clk); #1;
    if (!k) req0_valid = 0; else req1_valid = 0;
    @(negedge clk);
    cin = alu_cin;
    wait_rsp();
    lat = cyc - hs;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, d, n0;
    logic cin;
    #1 rst_n = 0;
    // Tie from reset: both continuously valid, grants must alternate starting at req0.
    req0_cmd = MOV; req0_val2 = 32'd5; req0_valid = 1;
    req1_cmd = MOV; req1_val2 = 32'd9; req1_valid = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    d = cyc;
    wait_rsp();
    chk("first grant latency", cyc - d, 32'd2);
    wait_log(4);
    req0_valid = 0; req1_valid = 0;
    if (log_res.size() >= 4) begin
      chk("tie id0", 32'(log_id[0]), 32'd0); chk("tie res0", log_res[0], 32'd5);
      chk("tie id1", 32'(log_id[1]), 32'd1); chk("tie res1", log_res[1], 32'd9);
      chk("tie id2", 32'(log_id[2]), 32'd0); chk("tie res2", log_res[2], 32'd5);
      chk("tie id3", 32'(log_id[3]), 32'd1); chk("tie res3", log_res[3], 32'd9);
    end else tmo("tie responses");

    do_op(0, 32'h7FFF_FFFF, 32'd1, ADD, 1, lat, cin);
    chk("add latency", lat, 32'd2);
    chk("add result", log_res[$], 32'h8000_0000);
    chk("add sr", 32'(log_sr[$]), 32'(4'b0011));
    chk("add status", 32'(status_reg), 32'(4'b0011));

    do_op(1, 32'd3, 32'd3, SUB, 0, lat, cin);
    chk("sub sr", 32'(log_sr[$]), 32'(4'b1100));
    chk("sub status held", 32'(status_reg), 32'(4'b0011));
    do_op(0, 32'd3, 32'd3, CMP, 0, lat, cin);
    chk("cmp status", 32'(status_reg), 32'(4'b1100));

    do_op(0, 32'd5, 32'd3, CMP, 0, lat, cin);
    chk("cmp53 status", 32'(status_reg), 32'(4'b0100));
    do_op(1, 32'd1, 32'd1, ADC, 0, lat, cin);
    chk("adc cin", 32'(cin), 32'd1);
    chk("adc result", log_res[$], 32'd3);

    do_op(0, 32'h12, 32'h34, UND, 0, lat, cin);
    chk("undef result", log_res[$], 32'h0BAD_0BAD);
    chk("undef status", 32'(status_reg), 32'(4'b0100));

    // Back-pressure: response held ten cycles while req1 waits.
    rsp_ready = 0;
    req0_val1 = 32'h8000_0000; req0_val2 = 0; req0_cmd = EOR; req0_s = 1; req0_valid = 1;
    wait_ready(0);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_val1 = 0; req1_val2 = 32'd7; req1_cmd = MOV; req1_s = 0; req1_valid = 1;
    wait_rsp();
    n0 = log_res.size();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall rsp_result", rsp_result, 32'h8000_0000);
      chk("stall rsp_sr", 32'(rsp_sr), 32'(4'b0010));
      chk("stall rsp_id", 32'(rsp_id), 32'd0);
      chk("stall req1_ready", 32'(req1_ready), 32'd0);
    end
    chk("stall no response", log_res.size(), n0);
    @(posedge clk); #1 rsp_ready = 1;
    @(posedge clk); #1;
    chk("release single rsp", log_res.size(), n0 + 1);
    wait_ready(1);
    @(posedge clk); #1 req1_valid = 0;
    wait_log(n0 + 2);
    chk("post-stall id", 32'(log_id[$]), 32'd1);
    chk("post-stall res", log_res[$], 32'd7);

    // Reset during EXEC aborts the op; a tie afterwards goes to req0.
    n0 = log_res.size();
    req1_val1 = 32'h8000_0000; req1_val2 = 32'h8000_0000; req1_cmd = ADD; req1_s = 1;
    req1_valid = 1;
    wait_ready(1);
    @(posedge clk); #1 req1_valid = 0;
    #1 rst_n = 0;
    req0_val2 = 32'h55; req0_cmd = MOV; req0_s = 0; req0_valid = 1;
    req1_val2 = 32'h66; req1_cmd = MOV; req1_s = 0; req1_valid = 1;
    #1;
    chk("exec rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec rst status", 32'(status_reg), 32'd0);
    chk("exec rst req0_ready", 32'(req0_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    wait_ready(0);
    chk("post-rst req1 not ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1 req0_valid = 0;
    wait_log(n0 + 1);
    chk("post-rst id", 32'(log_id[$]), 32'd0);
    chk("post-rst res", log_res[$], 32'h55);
    chk("post-rst status", 32'(status_reg), 32'd0);
    wait_log(n0 + 2);
    req1_valid = 0;
    chk("post-rst id2", 32'(log_id[$]), 32'd1);
    chk("post-rst res2", log_res[$], 32'h66);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous reset, active low.
REQ-002 The block SHALL provide these ports for requester k (k = 0, 1): reqk_valid  in  1  request pending; reqk_ready  out  1  request accepted this cycle; reqk_val1  in  32  operand 1; reqk_val2  in  32  operand 2; reqk_cmd  in  4  exe_cmd code (codebase *_EXE defines); reqk_s  in  1  commit flags.
REQ-003 The block SHALL provide these ports to the shared ALU: alu_val1  out  32; alu_val2  out  32; alu_cmd  out  4; alu_cin  out  1; alu_result  in  32; alu_sr  in  4  flags {Z,C,N,V}.
REQ-004 The block SHALL provide these response ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  requester index; rsp_result  out  32; rsp_sr  out  4  ALU flags of this op.
REQ-005 The block SHALL provide this status port: status_reg  out  4  committed {Z,C,N,V}.

Function
REQ-006 The block SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-007 In IDLE with no reqk_valid set, the block SHALL stay in IDLE with both reqk_ready low.
REQ-008 Arbitration in IDLE SHALL follow these rules: only one reqk_valid high -> grant k; both high -> grant the index != last_grant.
REQ-009 reqk_ready SHALL be combinational and high only in IDLE for the granted k; at most one ready SHALL be high per cycle.
REQ-010 On a handshake (valid & ready), the block SHALL latch val1, val2, cmd, s and id into operand registers, set last_grant = k, and go to EXEC.
REQ-011 alu_val1, alu_val2 and alu_cmd SHALL be driven from the operand registers in every state; the operand registers SHALL not change outside a handshake.
REQ-012 alu_cin SHALL equal status_reg[2] (committed C).
REQ-013 In EXEC, the block SHALL capture alu_result into rsp_result and alu_sr into rsp_sr, and go to RESP.
REQ-014 In EXEC, status_reg SHALL take alu_sr if the latched s = 1, or if cmd is CMP_EXE or TST_EXE; otherwise status_reg SHALL hold.
REQ-015 In RESP, rsp_valid SHALL be high and rsp_result, rsp_sr and rsp_id SHALL be stable until rsp_valid & rsp_ready; the block SHALL then go to IDLE.
REQ-016 Latency SHALL be: handshake in cycle N -> rsp_valid first high in cycle N+2; with rsp_ready tied high, throughput SHALL be one op per 3 cycles.
REQ-017 rsp_valid SHALL be low in IDLE and EXEC; no new grant SHALL occur before the response is accepted.
REQ-018 Back-pressure: rsp_ready low SHALL hold RESP indefinitely; requesters SHALL see ready low for the whole stall.
REQ-019 A requester dropping valid before a handshake SHALL cause no side effects.
REQ-020 The block SHALL pass undefined cmd codes to the ALU unchanged; the result SHALL be whatever the ALU returns, with no error signalled.
REQ-021 The fairness bound SHALL be: with both requesters continuously valid, grants alternate 0,1,0,1...

Reset
REQ-022 Assertion of rst_n = 0 SHALL immediately, without a clock, force: FSM = IDLE; last_grant = 1 (requester 0 wins first tie); status_reg = 4'b0000; operand registers, rsp_result and rsp_sr = 0; rsp_id = 0; rsp_valid = 0; both reqk_ready = 0.
REQ-023 Reset asserted in EXEC or RESP SHALL abort the operation: no status_reg update and no response.
REQ-024 After rst_n deasserts, the first grant SHALL be possible at the first rising clk edge.

Verification
REQ-025 The bench SHALL cover single op: req0 ADD 0x7FFFFFFF + 1, s=1 -> rsp at N+2, result 0x80000000, rsp_sr {0,0,1,1}, status_reg = 4'b0011.
REQ-026 The bench SHALL cover a tie: both valid from reset, req0 MOV 5, req1 MOV 9 -> responses id 0 (5) then id 1 (9); a second tie grants req0 again.
REQ-027 The bench SHALL cover flag gating: req1 SUB 3-3, s=0 -> rsp_sr Z=1, status_reg unchanged; then CMP 3,3 with s=0 -> status_reg Z=1.
REQ-028 The bench SHALL cover carry chaining: set C=1 via CMP 5,3; then ADC 1+1 s=0 -> alu_cin=1, result 3.
REQ-029 The bench SHALL cover back-pressure: rsp_ready low 10 cycles in RESP -> rsp fields stable, req ready low, single response on release.
REQ-030 The bench SHALL cover reset in EXEC: rst_n low mid-op -> rsp_valid 0, status_reg 0, next op granted to req0.
